// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;

  // Default reset PC and bubble instruction; fetch_stage exposes both as parameters.
  localparam logic [INSTR_W-1:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0800;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  // PC step: 16-bit modulo, so 16'hFFFE wraps to 16'h0000.
  function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read port between the fetch stage (master) and imem (slave).
//
// Handshake: the master raises imem_rd with imem_addr and holds both stable
// until the slave returns a one-cycle imem_done pulse carrying imem_data.
// imem_done may coincide with the first cycle of imem_rd (cache hit). Only one
// request is ever outstanding, and a request is never withdrawn before done.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [INSTR_W-1:0] imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_done;

  modport master (output imem_addr, output imem_rd, input imem_data, input imem_done);
  modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_done);

endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer that parks a returned word while decode is stalled.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INSTR_W-1:0] in_pc_plus2,
  output logic               full,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_pc_plus2
);

  // Full flag and payload; clear beats load, load beats unload.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full         <= 1'b0;
      out_instr    <= '0;
      out_pc_plus2 <= '0;
    end else if (load) begin
      full         <= 1'b1;
      out_instr    <= in_instr;
      out_pc_plus2 <= in_pc_plus2;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request, IF/ID register,
// decode back-pressure via a skid entry, redirects, halt and misalignment flag.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_id,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               halt_id,
  fetch_stage_if.master      mem,
  output logic [INSTR_W-1:0] instr_id,
  output logic [INSTR_W-1:0] pc_plus2_id,
  output logic               valid_id,
  output logic               err,
  output state_t             state_dbg
);

  state_t             state, state_nx;
  logic [INSTR_W-1:0] pc, pc_nx;
  logic [INSTR_W-1:0] req_addr;
  logic               pending, pending_nx;
  logic               err_set;
  logic               ifid_ld_mem, ifid_ld_skid, ifid_clr;
  logic               skid_load, skid_unload, skid_clear;
  logic               skid_full;
  logic [INSTR_W-1:0] skid_instr, skid_pc_plus2;
  logic [INSTR_W-1:0] ifid_instr, ifid_pc_plus2;
  logic               ifid_valid;
  logic               done;
  logic [INSTR_W-1:0] target_pc;

  assign done      = mem.imem_done;
  // A misaligned target still fetches, from the even address below it.
  assign target_pc = {redirect_pc[INSTR_W-1:1], 1'b0};

  fetch_skid u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .unload       (skid_unload),
    .clear        (skid_clear),
    .in_instr     (mem.imem_data),
    .in_pc_plus2  (pc_inc(pc)),
    .full         (skid_full),
    .out_instr    (skid_instr),
    .out_pc_plus2 (skid_pc_plus2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Next state and datapath controls. pending marks an in-flight request whose
  // data must be dropped (after a redirect, or while draining into HALTED).
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    pending_nx   = pending;
    err_set      = 1'b0;
    ifid_ld_mem  = 1'b0;
    ifid_ld_skid = 1'b0;
    ifid_clr     = 1'b0;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    case (state)
      FETCH, WAIT: begin
        if (redirect) begin
          pc_nx      = target_pc;
          err_set    = redirect_pc[0];
          pending_nx = !done;
          state_nx   = done ? FETCH : WAIT;
          ifid_clr   = 1'b1;
          skid_clear = 1'b1;
        end else if (halt_id) begin
          pending_nx = !done;
          state_nx   = HALTED;
          ifid_clr   = 1'b1;
          skid_clear = 1'b1;
        end else if (pending) begin
          if (done) begin
            pending_nx = 1'b0;
            state_nx   = FETCH;
          end else begin
            state_nx = WAIT;
          end
          if (!stall_id) ifid_clr = 1'b1;
        end else if (done) begin
          pc_nx = pc_inc(pc);
          if (stall_id) begin
            skid_load = 1'b1;
            state_nx  = HOLD;
          end else begin
            ifid_ld_mem = 1'b1;
            state_nx    = FETCH;
          end
        end else begin
          state_nx = WAIT;
          if (!stall_id) ifid_clr = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx      = target_pc;
          err_set    = redirect_pc[0];
          state_nx   = FETCH;
          ifid_clr   = 1'b1;
          skid_clear = 1'b1;
        end else if (halt_id) begin
          state_nx   = HALTED;
          ifid_clr   = 1'b1;
          skid_clear = 1'b1;
        end else if (!stall_id && skid_full) begin
          ifid_ld_skid = 1'b1;
          skid_unload  = 1'b1;
          state_nx     = FETCH;
        end
      end
      HALTED: begin
        if (pending && done) pending_nx = 1'b0;
      end
      default: state_nx = FETCH;
    endcase
  end

  // imem request outputs; the address is frozen in req_addr once issued.
  always_comb begin
    mem.imem_rd   = 1'b0;
    mem.imem_addr = (state == FETCH) ? pc : req_addr;
    if (!rst) begin
      case (state)
        FETCH, WAIT: mem.imem_rd = 1'b1;
        HALTED:      mem.imem_rd = pending;
        default:     mem.imem_rd = 1'b0;
      endcase
    end
  end

  // PC, request address, pending/err flags and the IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      pending       <= 1'b0;
      err           <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      pc       <= pc_nx;
      req_addr <= mem.imem_addr;
      pending  <= pending_nx;
      if (err_set) err <= 1'b1;
      if (ifid_clr) begin
        ifid_valid <= 1'b0;
      end else if (ifid_ld_mem) begin
        ifid_instr    <= mem.imem_data;
        ifid_pc_plus2 <= pc_inc(pc);
        ifid_valid    <= 1'b1;
      end else if (ifid_ld_skid) begin
        ifid_instr    <= skid_instr;
        ifid_pc_plus2 <= skid_pc_plus2;
        ifid_valid    <= 1'b1;
      end
    end
  end

  assign instr_id    = ifid_valid ? ifid_instr : NOP_INSTR;
  assign pc_plus2_id = ifid_pc_plus2;
  assign valid_id    = ifid_valid;
  assign state_dbg   = state;

endmodule
